// File: rtl/hack_defs.sv
//------------------------------------------------------------------------------
// Module : hack_defs
// Brief  : Shared word and address widths for the gate library.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package hack_defs;
   localparam int WORD_WIDTH = 16;
   localparam int ADDR_WIDTH = 3;
   localparam int NUM_WORDS  = 1 << ADDR_WIDTH;
endpackage

`default_nettype wire

// File: rtl/dmux.sv
//------------------------------------------------------------------------------
// Module : dmux
// Brief  : Two-way demultiplexer cell: routes in to a (sel=0) or b (sel=1).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmux (
   input  logic in,
   input  logic sel,
   output logic a,
   output logic b
);
   assign a = in & ~sel;
   assign b = in &  sel;
endmodule

`default_nettype wire

// File: rtl/dmux8way.sv
//------------------------------------------------------------------------------
// Module : dmux8way
// Brief  : Eight-way demultiplexer built as a three-level tree of dmux cells.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmux8way
   import hack_defs::*;
(
   input  logic                  in,
   input  logic [ADDR_WIDTH-1:0] sel,
   output logic                  a,
   output logic                  b,
   output logic                  c,
   output logic                  d,
   output logic                  e,
   output logic                  f,
   output logic                  g,
   output logic                  h
);
   logic lo_half, hi_half;
   logic q0, q1, q2, q3;

   // Split on the MSB first so each level consumes one select bit.
   dmux u_l0  (.in(in),      .sel(sel[2]), .a(lo_half), .b(hi_half));
   dmux u_l1a (.in(lo_half), .sel(sel[1]), .a(q0),      .b(q1));
   dmux u_l1b (.in(hi_half), .sel(sel[1]), .a(q2),      .b(q3));
   dmux u_l2a (.in(q0),      .sel(sel[0]), .a(a),       .b(b));
   dmux u_l2b (.in(q1),      .sel(sel[0]), .a(c),       .b(d));
   dmux u_l2c (.in(q2),      .sel(sel[0]), .a(e),       .b(f));
   dmux u_l2d (.in(q3),      .sel(sel[0]), .a(g),       .b(h));
endmodule

`default_nettype wire

// File: rtl/ram8.sv
//------------------------------------------------------------------------------
// Module : ram8
// Brief  : Eight-word register file with demuxed load and combinational read.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram8
   import hack_defs::*;
#(
   parameter int WIDTH = WORD_WIDTH,
   parameter int DEPTH = NUM_WORDS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      in,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] address,
   output logic [WIDTH-1:0]      out
);
   logic [DEPTH-1:0] enable;
   logic [WIDTH-1:0] word_q [DEPTH];
   logic [WIDTH-1:0] word_d [DEPTH];

   dmux8way u_load_dec (
      .in  (load),
      .sel (address),
      .a   (enable[0]),
      .b   (enable[1]),
      .c   (enable[2]),
      .d   (enable[3]),
      .e   (enable[4]),
      .f   (enable[5]),
      .g   (enable[6]),
      .h   (enable[7])
   );

   // An unknown enable falls to the hold path, so X/Z never corrupts a word.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         word_d[i] = word_q[i];
         if (enable[i]) begin
            word_d[i] = in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= word_d[i];
         end
      end
   end

   assign out = word_q[address];
endmodule

`default_nettype wire
